// File: rtl/key_extract_mt.sv
// key_extract_mt: multi-tenant lookup-key extractor between parser and lookup.
//
// Each PHV carries a tenant VID in its metadata. The VID selects one offset
// entry from a per-tenant table. That entry picks which 48/32/16-bit
// containers are copied into the lookup key. The datapath is a two-stage
// pipeline with a global stall enable (ready/valid backpressure).
//
// Optional build macro:
//   KEY_MASK_EN - adds a per-VID key mask table and its write port.
//                 When enabled, key_out = extracted key & mask.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   phv_in            PHV, MSB-first: c48[N-1..0], c32[N-1..0], c16[N-1..0], metadata
//   phv_valid_in      PHV valid
//   phv_ready_out     block accepts a PHV this cycle (combinational)
//   cfg_wr_en         offset-table write strobe
//   cfg_wr_addr       tenant entry to write
//   cfg_wr_data       container indices, MSB-first: 48-bit keys, 32-bit keys, 16-bit keys
//   cfg_mask_wr_en    mask-table write strobe (KEY_MASK_EN only)
//   cfg_mask_wr_data  mask value (KEY_MASK_EN only)
//   phv_out           accepted PHV, unchanged
//   phv_valid_out     output valid
//   key_out           lookup key, same field order as cfg_wr_data
//   key_valid_out     same as phv_valid_out
//   out_ready_in      downstream accepts the output
module key_extract_mt #(
    parameter int unsigned C_CONT_NUM = 8,
    parameter int unsigned C_KEYS     = 2,
    parameter int unsigned C_VID_W    = 4,
    parameter int unsigned C_META_W   = 356,
    parameter int unsigned C_VID_LSB  = 128,
    localparam int unsigned IDX_W     = (C_CONT_NUM > 1) ? $clog2(C_CONT_NUM) : 1,
    localparam int unsigned PHV_LEN   = C_CONT_NUM * 96 + C_META_W,
    localparam int unsigned KEY_LEN   = C_KEYS * 96,
    localparam int unsigned OFF_W     = 3 * C_KEYS * IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    output logic               phv_ready_out,
    input  logic               cfg_wr_en,
    input  logic [C_VID_W-1:0] cfg_wr_addr,
    input  logic [OFF_W-1:0]   cfg_wr_data,
`ifdef KEY_MASK_EN
    input  logic               cfg_mask_wr_en,
    input  logic [KEY_LEN-1:0] cfg_mask_wr_data,
`endif
    output logic [PHV_LEN-1:0] phv_out,
    output logic               phv_valid_out,
    output logic [KEY_LEN-1:0] key_out,
    output logic               key_valid_out,
    input  logic               out_ready_in
);

    localparam int unsigned DEPTH    = 1 << C_VID_W;
    // Container arrays are padded to a power of two so any index value is a
    // legal array access; the padding entries read as zero.
    localparam int unsigned CONT_PAD = 1 << IDX_W;

    // Container base bit positions inside the PHV.
    localparam int unsigned B16 = C_META_W;
    localparam int unsigned B32 = B16 + C_CONT_NUM * 16;
    localparam int unsigned B48 = B32 + C_CONT_NUM * 32;

    // Class base bit positions inside the key.
    localparam int unsigned K32 = C_KEYS * 16;
    localparam int unsigned K48 = C_KEYS * 48;

    logic               en;
    logic               accept;
    logic [C_VID_W-1:0] vid;

    logic               s1_valid_q;
    logic [PHV_LEN-1:0] s1_phv_q;
    logic [OFF_W-1:0]   s1_entry_q;
    logic               s2_valid_q;

    logic [OFF_W-1:0]   off_tbl_q [DEPTH];

`ifdef KEY_MASK_EN
    logic [KEY_LEN-1:0] mask_tbl_q [DEPTH];
    logic [KEY_LEN-1:0] s1_mask_q;
`endif

    logic [47:0]        c48 [CONT_PAD];
    logic [31:0]        c32 [CONT_PAD];
    logic [15:0]        c16 [CONT_PAD];
    logic [KEY_LEN-1:0] key_d;

    // A full S2 that downstream is not taking freezes the whole pipe.
    assign en            = !s2_valid_q || out_ready_in;
    assign phv_ready_out = en;
    assign accept        = phv_valid_in && en;
    assign vid           = phv_in[C_VID_LSB +: C_VID_W];

    assign phv_valid_out = s2_valid_q;
    assign key_valid_out = s2_valid_q;

    // Slice the S1 PHV into per-class container arrays.
    for (genvar i = 0; i < CONT_PAD; i++) begin : g_cont
        if (i < C_CONT_NUM) begin : g_real
            assign c48[i] = s1_phv_q[B48 + i * 48 +: 48];
            assign c32[i] = s1_phv_q[B32 + i * 32 +: 32];
            assign c16[i] = s1_phv_q[B16 + i * 16 +: 16];
        end else begin : g_pad
            assign c48[i] = '0;
            assign c32[i] = '0;
            assign c16[i] = '0;
        end
    end

    // Key field k of each class sits at the same relative position as its
    // index field in the offset entry (key0 most significant).
    always_comb begin
        key_d = '0;
        for (int unsigned k = 0; k < C_KEYS; k++) begin
            key_d[K48 + (C_KEYS - 1 - k) * 48 +: 48] =
                c48[s1_entry_q[(3 * C_KEYS - 1 - k) * IDX_W +: IDX_W]];
            key_d[K32 + (C_KEYS - 1 - k) * 32 +: 32] =
                c32[s1_entry_q[(2 * C_KEYS - 1 - k) * IDX_W +: IDX_W]];
            key_d[(C_KEYS - 1 - k) * 16 +: 16] =
                c16[s1_entry_q[(C_KEYS - 1 - k) * IDX_W +: IDX_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_phv_q   <= '0;
            s1_entry_q <= '0;
            s2_valid_q <= 1'b0;
            phv_out    <= '0;
            key_out    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                off_tbl_q[i] <= '0;
            end
`ifdef KEY_MASK_EN
            s1_mask_q <= '1;
            for (int i = 0; i < DEPTH; i++) begin
                mask_tbl_q[i] <= '1;
            end
`endif
        end else begin
            if (en) begin
                s1_valid_q <= phv_valid_in;
                // Table reads see the pre-write value, so a PHV accepted in
                // the same cycle as a write to its VID uses the old entry.
                if (accept) begin
                    s1_phv_q   <= phv_in;
                    s1_entry_q <= off_tbl_q[vid];
`ifdef KEY_MASK_EN
                    s1_mask_q  <= mask_tbl_q[vid];
`endif
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    phv_out <= s1_phv_q;
`ifdef KEY_MASK_EN
                    key_out <= key_d & s1_mask_q;
`else
                    key_out <= key_d;
`endif
                end
            end
            // Configuration is independent of the stall.
            if (cfg_wr_en) begin
                off_tbl_q[cfg_wr_addr] <= cfg_wr_data;
            end
`ifdef KEY_MASK_EN
            if (cfg_mask_wr_en) begin
                mask_tbl_q[cfg_wr_addr] <= cfg_mask_wr_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_extract_mt.sv
module tb_key_extract_mt;

    localparam int C_CONT_NUM = 8;
    localparam int C_KEYS     = 2;
    localparam int C_VID_W    = 4;
    localparam int C_META_W   = 356;
    localparam int C_VID_LSB  = 128;
    localparam int IDX_W      = 3;
    localparam int PHV_LEN    = C_CONT_NUM * 96 + C_META_W;
    localparam int KEY_LEN    = C_KEYS * 96;
    localparam int OFF_W      = 3 * C_KEYS * IDX_W;
    localparam int B16        = C_META_W;
    localparam int B32        = B16 + C_CONT_NUM * 16;
    localparam int B48        = B32 + C_CONT_NUM * 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic               phv_ready_out;
    logic               cfg_wr_en;
    logic [C_VID_W-1:0] cfg_wr_addr;
    logic [OFF_W-1:0]   cfg_wr_data;
    logic               cfg_mask_wr_en;
    logic [KEY_LEN-1:0] cfg_mask_wr_data;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic [KEY_LEN-1:0] key_out;
    logic               key_valid_out;
    logic               out_ready_in;

    always #5 clk = ~clk;

    key_extract_mt #(
        .C_CONT_NUM (C_CONT_NUM),
        .C_KEYS     (C_KEYS),
        .C_VID_W    (C_VID_W),
        .C_META_W   (C_META_W),
        .C_VID_LSB  (C_VID_LSB)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .phv_in           (phv_in),
        .phv_valid_in     (phv_valid_in),
        .phv_ready_out    (phv_ready_out),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_addr      (cfg_wr_addr),
        .cfg_wr_data      (cfg_wr_data),
`ifdef KEY_MASK_EN
        .cfg_mask_wr_en   (cfg_mask_wr_en),
        .cfg_mask_wr_data (cfg_mask_wr_data),
`endif
        .phv_out          (phv_out),
        .phv_valid_out    (phv_valid_out),
        .key_out          (key_out),
        .key_valid_out    (key_valid_out),
        .out_ready_in     (out_ready_in)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: tenant tables and expected-output scoreboard.
    logic [OFF_W-1:0]   m_off  [16];
    logic [KEY_LEN-1:0] m_mask [16];
    logic [PHV_LEN-1:0] exp_phv_q [$];
    logic [KEY_LEN-1:0] exp_key_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_off[i]  = '0;
            m_mask[i] = '1;
        end
        exp_phv_q.delete();
        exp_key_q.delete();
    endfunction

    // Key = concatenation of selected containers, built by shifting the PHV.
    function automatic logic [KEY_LEN-1:0] model_key(input logic [PHV_LEN-1:0] p,
                                                     input logic [OFF_W-1:0] e);
        logic [KEY_LEN-1:0] key;
        logic [PHV_LEN-1:0] t;
        logic [63:0]        m;
        int                 cls, w, base, idx;
        key = '0;
        for (int f = 0; f < 3 * C_KEYS; f++) begin
            cls  = f / C_KEYS;
            w    = (cls == 0) ? 48 : (cls == 1) ? 32 : 16;
            base = (cls == 0) ? B48 : (cls == 1) ? B32 : B16;
            idx  = (int'(e) >> ((3 * C_KEYS - 1 - f) * IDX_W)) % (1 << IDX_W);
            t    = p >> (base + idx * w);
            m    = (64'd1 << w) - 64'd1;
            key  = key << w;
            if (idx < C_CONT_NUM) key = key | KEY_LEN'(t[63:0] & m);
        end
        return key;
    endfunction

    function automatic logic [PHV_LEN-1:0] put(input logic [PHV_LEN-1:0] p, input int cls,
                                               input int idx, input logic [47:0] v);
        logic [PHV_LEN-1:0] m;
        int                 w, pos;
        w   = (cls == 0) ? 48 : (cls == 1) ? 32 : 16;
        pos = ((cls == 0) ? B48 : (cls == 1) ? B32 : B16) + idx * w;
        m   = PHV_LEN'((64'd1 << w) - 64'd1);
        return (p & ~(m << pos)) | ((PHV_LEN'(v) & m) << pos);
    endfunction

    function automatic logic [PHV_LEN-1:0] with_vid(input logic [PHV_LEN-1:0] p, input int v);
        p[C_VID_LSB +: C_VID_W] = C_VID_W'(v);
        return p;
    endfunction

    function automatic logic [PHV_LEN-1:0] rand_phv();
        logic [36*32-1:0] t;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom();
        return t[PHV_LEN-1:0];
    endfunction

    // One cycle, entered just after a falling edge: check outputs against the
    // scoreboard, drive inputs, record the handshake in the model, advance.
    task automatic step(input logic vin, input logic [PHV_LEN-1:0] p, input logic ordy,
                        input logic we, input logic [C_VID_W-1:0] wa,
                        input logic [OFF_W-1:0] wd, input logic mwe,
                        input logic [KEY_LEN-1:0] md, input logic use_k,
                        input logic [KEY_LEN-1:0] kx, output logic acc);
        logic [C_VID_W-1:0] v;
        if (phv_valid_out) begin
            if (exp_key_q.size() == 0) begin
                check("spurious_out", 256'(1), 256'(0));
            end else begin
                check("key_out", 256'(key_out), 256'(exp_key_q[0]));
                for (int c = 0; c < 5; c++)
                    check($sformatf("phv_out_chunk%0d", c), 256'(phv_out >> (c * 256)),
                          256'(exp_phv_q[0] >> (c * 256)));
            end
        end
        check("key_valid_out", 256'(key_valid_out), 256'(phv_valid_out));
        out_ready_in     = ordy;
        phv_valid_in     = vin;
        phv_in           = p;
        cfg_wr_en        = we;
        cfg_wr_addr      = wa;
        cfg_wr_data      = wd;
        cfg_mask_wr_en   = mwe;
        cfg_mask_wr_data = md;
        #1;
        check("phv_ready_out", 256'(phv_ready_out), 256'(!phv_valid_out || ordy));
        if (phv_valid_out && ordy && exp_key_q.size() != 0) begin
            void'(exp_key_q.pop_front());
            void'(exp_phv_q.pop_front());
        end
        acc = vin && phv_ready_out;
        if (acc) begin
            v = p[C_VID_LSB +: C_VID_W];
            exp_phv_q.push_back(p);
            exp_key_q.push_back(use_k ? kx : (model_key(p, m_off[v]) & m_mask[v]));
        end
        if (we) m_off[wa] = wd;
`ifdef KEY_MASK_EN
        if (mwe) m_mask[wa] = md;
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, acc);
    endtask

    task automatic send(input logic [PHV_LEN-1:0] p, input logic use_k,
                        input logic [KEY_LEN-1:0] kx);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 10 && !acc; t++)
            step(1'b1, p, 1'b1, 1'b0, '0, '0, 1'b0, '0, use_k, kx, acc);
        if (!acc) check("send_timeout", 256'(0), 256'(1));
    endtask

    logic [PHV_LEN-1:0] p1, p2;
    logic [KEY_LEN-1:0] k1, k2, k3, mk, md_r;
    logic [OFF_W-1:0]   e76, e67;
    logic [PHV_LEN-1:0] sp [4];
    logic               acc, saw_stall;
    int                 sent;

    initial begin
        model_reset();
        rst = 1'b1;
        phv_in = '0; phv_valid_in = 1'b0; out_ready_in = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_mask_wr_en = 1'b0; cfg_mask_wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_phv_valid", 256'(phv_valid_out), 256'(0));
        check("rst_key_valid", 256'(key_valid_out), 256'(0));
        check("rst_phv_out_zero", 256'(|phv_out), 256'(0));
        check("rst_key_out", 256'(key_out), 256'(0));
        check("rst_ready", 256'(phv_ready_out), 256'(1));
        rst = 1'b0;

        // Default entries pick container 0 everywhere; latency is two cycles.
        p1 = '0;
        p1 = put(p1, 0, 0, 48'h111111111111);
        p1 = put(p1, 1, 0, 48'h22222222);
        p1 = put(p1, 2, 0, 48'h3333);
        k1 = {48'h111111111111, 48'h111111111111, 32'h22222222, 32'h22222222,
              16'h3333, 16'h3333};
        step(1'b1, p1, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, k1, acc);
        check("t1_accept", 256'(acc), 256'(1));
        check("t1_lat1_valid", 256'(phv_valid_out), 256'(0));
        idle(1);
        check("t1_lat2_valid", 256'(phv_valid_out), 256'(1));
        idle(2);

        // Tenant 3 entry {7,6,7,6,7,6}; tenant 5 still at default.
        e76 = {3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6};
        e67 = {3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
        p2 = p1;
        p2 = put(p2, 0, 7, 48'hffffffffffff);
        p2 = put(p2, 0, 6, 48'heeeeeeeeeeee);
        p2 = put(p2, 1, 7, 48'hcccccccc);
        p2 = put(p2, 1, 6, 48'hbbbbbbbb);
        p2 = put(p2, 2, 7, 48'hffff);
        p2 = put(p2, 2, 6, 48'heeee);
        k2 = {48'hffffffffffff, 48'heeeeeeeeeeee, 32'hcccccccc, 32'hbbbbbbbb,
              16'hffff, 16'heeee};
        k3 = {48'heeeeeeeeeeee, 48'hffffffffffff, 32'hbbbbbbbb, 32'hcccccccc,
              16'heeee, 16'hffff};
        step(1'b0, '0, 1'b1, 1'b1, 4'd3, e76, 1'b0, '0, 1'b0, '0, acc);
        send(with_vid(p2, 3), 1'b1, k2);
        send(with_vid(p2, 5), 1'b1, k1);
        idle(3);

        // Write and PHV to the same tenant in one cycle: PHV sees the old entry.
        step(1'b1, with_vid(p2, 3), 1'b1, 1'b1, 4'd3, e67, 1'b0, '0, 1'b1, k2, acc);
        check("t3_accept", 256'(acc), 256'(1));
        send(with_vid(p2, 3), 1'b1, k3);
        idle(3);

`ifdef KEY_MASK_EN
        mk = {96'hffffffffffffffffffffffff, 96'h0};
        step(1'b0, '0, 1'b1, 1'b0, 4'd3, '0, 1'b1, mk, 1'b0, '0, acc);
        send(with_vid(p2, 3), 1'b1, {k3[191:96], 96'h0});
        idle(3);
`endif

        // Four back-to-back PHVs with downstream stalled for three cycles.
        for (int i = 0; i < 4; i++) sp[i] = with_vid(rand_phv(), i);
        sent = 0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 20 && (sent < 4 || exp_key_q.size() != 0); cyc++) begin
            step(sent < 4, (sent < 4) ? sp[sent] : '0, !(cyc >= 1 && cyc <= 3),
                 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, acc);
            if (sent < 4 && !acc) saw_stall = 1'b1;
            if (acc) sent++;
        end
        check("stall_ready_low", 256'(saw_stall), 256'(1));
        check("stall_all_sent", 256'(sent), 256'(4));
        check("stall_drained", 256'(exp_key_q.size()), 256'(0));

        // Reset with two PHVs in flight drops them and clears the table.
        send(with_vid(rand_phv(), 3), 1'b0, '0);
        send(with_vid(rand_phv(), 3), 1'b0, '0);
        rst = 1'b1;
        phv_valid_in = 1'b0; cfg_wr_en = 1'b0; cfg_mask_wr_en = 1'b0; out_ready_in = 1'b1;
        @(negedge clk);
        check("rst2_phv_valid", 256'(phv_valid_out), 256'(0));
        check("rst2_key_valid", 256'(key_valid_out), 256'(0));
        check("rst2_key_out", 256'(key_out), 256'(0));
        check("rst2_phv_out_zero", 256'(|phv_out), 256'(0));
        rst = 1'b0;
        model_reset();
        send(with_vid(p2, 3), 1'b1, k1);
        idle(4);

        // Randomized traffic with config writes and backpressure.
        for (int n = 0; n < 400; n++) begin
            md_r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            step(($urandom() % 4) != 0, with_vid(rand_phv(), int'($urandom() % 4)),
                 ($urandom() % 4) != 0, ($urandom() % 8) == 0, C_VID_W'($urandom() % 4),
                 OFF_W'($urandom()),
`ifdef KEY_MASK_EN
                 ($urandom() % 8) == 0,
`else
                 1'b0,
`endif
                 md_r, 1'b0, '0, acc);
        end
        for (int n = 0; n < 20 && exp_key_q.size() != 0; n++) idle(1);
        check("final_drained", 256'(exp_key_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
